// File: rtl/axi_slave_mem.sv
// AXI3-style INCR-burst slave over a 64-bit word array; R data 1 cycle after AR, B 1 cycle after last W.
// One write and one read outstanding; BVALID/RVALID hold payload until READY, AW/AR stall while busy.
module axi_slave_mem #(
  parameter int ID_BITS   = 4,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ID_BITS-1:0]   AWID0,
  input  logic [31:0]          AWADDR0,
  input  logic [LEN_BITS-1:0]  AWLEN0,
  input  logic [SIZE_BITS-1:0] AWSIZE0,
  input  logic                 AWVALID0,
  output logic                 AWREADY0,
  input  logic [ID_BITS-1:0]   WID0,
  input  logic [63:0]          WDATA0,
  input  logic [7:0]           WSTRB0,
  input  logic                 WLAST0,
  input  logic                 WVALID0,
  output logic                 WREADY0,
  output logic [ID_BITS-1:0]   BID0,
  output logic [1:0]           BRESP0,
  output logic                 BVALID0,
  input  logic                 BREADY0,
  input  logic [ID_BITS-1:0]   ARID0,
  input  logic [31:0]          ARADDR0,
  input  logic [LEN_BITS-1:0]  ARLEN0,
  input  logic [SIZE_BITS-1:0] ARSIZE0,
  input  logic                 ARVALID0,
  output logic                 ARREADY0,
  output logic [ID_BITS-1:0]   RID0,
  output logic [63:0]          RDATA0,
  output logic [1:0]           RRESP0,
  output logic                 RLAST0,
  output logic                 RVALID0,
  input  logic                 RREADY0
);
  localparam int IDX = $clog2(MEM_DEPTH);
  localparam logic [1:0] WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_RESP = 2'd2;
  localparam logic [0:0] RD_IDLE = 1'b0, RD_DATA = 1'b1;
  localparam logic [SIZE_BITS-1:0] MAX_SIZE = SIZE_BITS'(3);
  localparam logic [LEN_BITS-1:0]  LEN_ONE  = LEN_BITS'(1);

  logic [63:0] mem [MEM_DEPTH];

  logic [1:0]           wr_state;
  logic [ID_BITS-1:0]   wr_id;
  logic [31:0]          wr_addr;
  logic [LEN_BITS-1:0]  wr_len, wr_cnt;
  logic [SIZE_BITS-1:0] wr_size;
  logic                 wr_err;
  logic                 aw_fire, w_fire, w_last_beat, w_err_next;

  logic [0:0]           rd_state;
  logic [31:0]          rd_addr, rd_next_addr;
  logic [LEN_BITS-1:0]  rd_len, rd_cnt;
  logic [SIZE_BITS-1:0] rd_size;
  logic                 rd_err;
  logic                 ar_fire, r_fire, ar_err;

  assign aw_fire     = AWVALID0 && AWREADY0;
  assign w_fire      = WVALID0 && WREADY0;
  assign w_last_beat = (wr_cnt == wr_len);
  // The burst length comes from AWLEN; a misplaced WLAST only flags an error.
  assign w_err_next  = wr_err | (WID0 != wr_id) | (WLAST0 != w_last_beat);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      AWREADY0 <= 1'b0;
      WREADY0  <= 1'b0;
      BVALID0  <= 1'b0;
      BID0     <= '0;
      BRESP0   <= 2'b00;
      wr_id    <= '0;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_cnt   <= '0;
      wr_size  <= '0;
      wr_err   <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          AWREADY0 <= 1'b1;
          if (aw_fire) begin
            AWREADY0 <= 1'b0;
            WREADY0  <= 1'b1;
            wr_id    <= AWID0;
            wr_addr  <= AWADDR0;
            wr_len   <= AWLEN0;
            wr_size  <= AWSIZE0;
            wr_cnt   <= '0;
            wr_err   <= (AWSIZE0 > MAX_SIZE);
            wr_state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_fire) begin
            wr_err  <= w_err_next;
            wr_cnt  <= wr_cnt + LEN_ONE;
            wr_addr <= wr_addr + (32'd1 << wr_size);
            if (w_last_beat) begin
              WREADY0  <= 1'b0;
              BVALID0  <= 1'b1;
              BID0     <= wr_id;
              BRESP0   <= w_err_next ? 2'b10 : 2'b00;
              wr_state <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (BVALID0 && BREADY0) begin
            BVALID0  <= 1'b0;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Array has no reset so earlier bursts survive a reset pulse.
  always_ff @(posedge clk) begin
    if (!reset && w_fire && !wr_err) begin
      for (int i = 0; i < 8; i++) begin
        if (WSTRB0[i]) mem[wr_addr[3 +: IDX]][8*i +: 8] <= WDATA0[8*i +: 8];
      end
    end
  end

  assign ar_fire      = ARVALID0 && ARREADY0;
  assign r_fire       = RVALID0 && RREADY0;
  assign ar_err       = (ARSIZE0 > MAX_SIZE);
  assign rd_next_addr = rd_addr + (32'd1 << rd_size);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      ARREADY0 <= 1'b0;
      RID0     <= '0;
      RDATA0   <= '0;
      RRESP0   <= 2'b00;
      RLAST0   <= 1'b0;
      RVALID0  <= 1'b0;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_cnt   <= '0;
      rd_size  <= '0;
      rd_err   <= 1'b0;
    end else if (rd_state == RD_IDLE) begin
      ARREADY0 <= 1'b1;
      if (ar_fire) begin
        ARREADY0 <= 1'b0;
        RID0     <= ARID0;
        rd_addr  <= ARADDR0;
        rd_len   <= ARLEN0;
        rd_size  <= ARSIZE0;
        rd_cnt   <= '0;
        rd_err   <= ar_err;
        RRESP0   <= ar_err ? 2'b10 : 2'b00;
        RDATA0   <= ar_err ? 64'd0 : mem[ARADDR0[3 +: IDX]];
        RLAST0   <= (ARLEN0 == '0);
        RVALID0  <= 1'b1;
        rd_state <= RD_DATA;
      end
    end else begin
      if (r_fire) begin
        if (RLAST0) begin
          RVALID0  <= 1'b0;
          RLAST0   <= 1'b0;
          rd_state <= RD_IDLE;
        end else begin
          // Next beat is fetched in the accepting cycle so beats stream without a bubble.
          rd_addr <= rd_next_addr;
          rd_cnt  <= rd_cnt + LEN_ONE;
          RDATA0  <= rd_err ? 64'd0 : mem[rd_next_addr[3 +: IDX]];
          RLAST0  <= ((rd_cnt + LEN_ONE) == rd_len);
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized and directed bench for axi_slave_mem against a word-array reference model.
module tb_axi_slave_mem;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  AWID0 = '0, WID0 = '0, BID0, ARID0 = '0, RID0;
  logic [31:0] AWADDR0 = '0, ARADDR0 = '0;
  logic [3:0]  AWLEN0 = '0, ARLEN0 = '0;
  logic [2:0]  AWSIZE0 = '0, ARSIZE0 = '0;
  logic        AWVALID0 = 1'b0, AWREADY0, WLAST0 = 1'b0, WVALID0 = 1'b0, WREADY0;
  logic [63:0] WDATA0 = '0, RDATA0;
  logic [7:0]  WSTRB0 = '0;
  logic [1:0]  BRESP0, RRESP0;
  logic        BVALID0, BREADY0 = 1'b0, ARVALID0 = 1'b0, ARREADY0;
  logic        RLAST0, RVALID0, RREADY0 = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem_m   [DEPTH];
  bit          known_m [DEPTH];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];

  axi_slave_mem dut (
    .clk(clk), .reset(reset),
    .AWID0(AWID0), .AWADDR0(AWADDR0), .AWLEN0(AWLEN0), .AWSIZE0(AWSIZE0),
    .AWVALID0(AWVALID0), .AWREADY0(AWREADY0),
    .WID0(WID0), .WDATA0(WDATA0), .WSTRB0(WSTRB0), .WLAST0(WLAST0),
    .WVALID0(WVALID0), .WREADY0(WREADY0),
    .BID0(BID0), .BRESP0(BRESP0), .BVALID0(BVALID0), .BREADY0(BREADY0),
    .ARID0(ARID0), .ARADDR0(ARADDR0), .ARLEN0(ARLEN0), .ARSIZE0(ARSIZE0),
    .ARVALID0(ARVALID0), .ARREADY0(ARREADY0),
    .RID0(RID0), .RDATA0(RDATA0), .RRESP0(RRESP0), .RLAST0(RLAST0),
    .RVALID0(RVALID0), .RREADY0(RREADY0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size);
    int t = 0;
    AWID0 = id; AWADDR0 = addr; AWLEN0 = len; AWSIZE0 = size; AWVALID0 = 1'b1;
    while (!AWREADY0 && t < 40) begin tick(); t++; end
    check("aw_accept", 64'(t < 40), 64'd1);
    tick();
    AWVALID0 = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size);
    int t = 0;
    ARID0 = id; ARADDR0 = addr; ARLEN0 = len; ARSIZE0 = size; ARVALID0 = 1'b1;
    while (!ARREADY0 && t < 40) begin tick(); t++; end
    check("ar_accept", 64'(t < 40), 64'd1);
    tick();
    ARVALID0 = 1'b0;
  endtask

  task automatic w_beat(input logic [3:0] id, input logic [63:0] data, input logic [7:0] strb,
                        input bit last);
    int t = 0;
    WID0 = id; WDATA0 = data; WSTRB0 = strb; WLAST0 = last; WVALID0 = 1'b1;
    while (!WREADY0 && t < 20) begin tick(); t++; end
    check("w_accept", 64'(t < 20), 64'd1);
    tick();
    WVALID0 = 1'b0; WLAST0 = 1'b0;
  endtask

  // Model: a byte-strobed word array; bursts with any error leave their words untrusted.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input bit bad_wid, input int last_at,
                          input int b_delay);
    logic [31:0] a = addr;
    int idx, t;
    bit err = (size > 3) || bad_wid || (last_at != len);
    aw_send(id, addr, 4'(len), size);
    for (int b = 0; b <= len; b++) begin
      w_beat((bad_wid && b == len) ? (id ^ 4'h1) : id, wd[b], ws[b], b == last_at);
      idx = int'((a >> 3) % DEPTH);
      if (err) known_m[idx] = 1'b0;
      else begin
        for (int k = 0; k < 8; k++)
          if (ws[b][k]) mem_m[idx][8*k +: 8] = wd[b][8*k +: 8];
        if (ws[b] == 8'hFF) known_m[idx] = 1'b1;
      end
      a = a + (32'd1 << size);
    end
    t = 0;
    while (!BVALID0 && t < 20) begin tick(); t++; end
    check("b_latency", 64'(t), 64'd0);
    for (int d = 0; d < b_delay; d++) begin
      check("b_hold_vld", 64'(BVALID0), 64'd1);
      tick();
    end
    check("bvalid", 64'(BVALID0), 64'd1);
    check("bid", 64'(BID0), 64'(id));
    check("bresp", 64'(BRESP0), err ? 64'd2 : 64'd0);
    BREADY0 = 1'b1;
    tick();
    BREADY0 = 1'b0;
    check("b_drop", 64'(BVALID0), 64'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input bit stall);
    logic [31:0] a = addr;
    logic [63:0] exp;
    int idx, t;
    bit err = (size > 3);
    ar_send(id, addr, 4'(len), size);
    for (int b = 0; b <= len; b++) begin
      t = 0;
      while (!RVALID0 && t < 20) begin tick(); t++; end
      check("r_latency", 64'(t), 64'd0);
      idx = int'((a >> 3) % DEPTH);
      exp = err ? 64'd0 : mem_m[idx];
      check("rid", 64'(RID0), 64'(id));
      check("rresp", 64'(RRESP0), err ? 64'd2 : 64'd0);
      check("rlast", 64'(RLAST0), 64'(b == len));
      if (err || known_m[idx]) check("rdata", RDATA0, exp);
      if (stall && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) tick();
        check("r_hold_vld", 64'(RVALID0), 64'd1);
        if (err || known_m[idx]) check("r_hold_data", RDATA0, exp);
      end
      RREADY0 = 1'b1;
      tick();
      RREADY0 = 1'b0;
      a = a + (32'd1 << size);
    end
    check("r_drop", 64'(RVALID0), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    int rl;
    logic [2:0] rs;
    bit bv;
    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;

    repeat (3) tick();
    check("rst_awready", 64'(AWREADY0), 64'd0);
    check("rst_arready", 64'(ARREADY0), 64'd0);
    check("rst_wready", 64'(WREADY0), 64'd0);
    check("rst_bvalid", 64'(BVALID0), 64'd0);
    check("rst_rvalid", 64'(RVALID0), 64'd0);
    check("rst_rdata", RDATA0, 64'd0);
    reset = 1'b0;
    repeat (2) tick();
    check("post_rst_awready", 64'(AWREADY0), 64'd1);

    // single beat
    wd[0] = 64'hDEADBEEF_CAFEF00D; ws[0] = 8'hFF;
    do_write(4'd3, 32'h10, 0, 3'd3, 1'b0, 0, 0);
    do_read(4'd5, 32'h10, 0, 3'd3, 1'b0);

    // 4-beat burst, B stalled, R throttled
    for (int b = 0; b < 4; b++) begin wd[b] = 64'(b + 1); ws[b] = 8'hFF; end
    do_write(4'd7, 32'h100, 3, 3'd3, 1'b0, 3, 3);
    do_read(4'd8, 32'h100, 3, 3'd3, 1'b1);
    do_read(4'd9, 32'h100, 3, 3'd3, 1'b1);

    // byte strobes over a preset word
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    do_write(4'd1, 32'h200, 0, 3'd3, 1'b0, 0, 0);
    wd[0] = 64'd0; ws[0] = 8'h0F;
    do_write(4'd1, 32'h200, 0, 3'd3, 1'b0, 0, 1);
    do_read(4'd2, 32'h200, 0, 3'd3, 1'b0);

    // error responses
    for (int b = 0; b < 4; b++) begin wd[b] = 64'(b + 32'h50); ws[b] = 8'hFF; end
    do_write(4'd4, 32'h300, 3, 3'd3, 1'b0, 2, 0);
    do_write(4'd6, 32'h340, 1, 3'd3, 1'b1, 1, 0);
    do_write(4'd6, 32'h380, 1, 3'd4, 1'b0, 1, 0);
    do_read(4'd10, 32'h100, 2, 3'd4, 1'b1);

    // index wrap
    wd[0] = 64'hAAAA_0000_1111_2222; wd[1] = 64'hBBBB_3333_4444_5555; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(4'd11, 32'((DEPTH - 1) * 8), 1, 3'd3, 1'b0, 1, 0);
    do_read(4'd12, 32'((DEPTH - 1) * 8), 0, 3'd3, 1'b0);
    do_read(4'd13, 32'h0, 0, 3'd3, 1'b0);
    do_read(4'd14, 32'((DEPTH - 1) * 8), 1, 3'd3, 1'b0);

    // reset pulsed mid-burst
    aw_send(4'd1, 32'h400, 4'd3, 3'd3);
    w_beat(4'd1, 64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0);
    mem_m[32'h400 >> 3] = 64'h1234_5678_9ABC_DEF0;
    known_m[32'h400 >> 3] = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_wready", 64'(WREADY0), 64'd0);
    bv = 1'b0;
    repeat (4) begin tick(); if (BVALID0) bv = 1'b1; end
    check("midrst_no_bvalid", 64'(bv), 64'd0);
    check("midrst_awready", 64'(AWREADY0), 64'd1);
    do_read(4'd2, 32'h400, 0, 3'd3, 1'b0);
    wd[0] = 64'h0F0F; wd[1] = 64'hF0F0; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(4'd4, 32'h400, 1, 3'd3, 1'b0, 1, 0);
    do_read(4'd5, 32'h400, 1, 3'd3, 1'b0);

    // concurrent write and read on disjoint words
    for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    fork
      do_write(4'd3, 32'h1800, 3, 3'd3, 1'b0, 3, 1);
      do_read(4'd7, 32'h100, 3, 3'd3, 1'b1);
    join
    do_read(4'd7, 32'h1800, 3, 3'd3, 1'b0);

    // randomized bursts
    for (int k = 0; k < 25; k++) begin
      ra = $urandom;
      rl = $urandom_range(0, 7);
      rs = 3'($urandom_range(0, 3));
      for (int b = 0; b <= rl; b++) begin
        wd[b] = {$urandom, $urandom};
        ws[b] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      end
      do_write(4'($urandom), ra, rl, rs, 1'b0, rl, $urandom_range(0, 2));
      do_read(4'($urandom), ra, rl, rs, 1'b1);
      do_read(4'($urandom), $urandom, $urandom_range(0, 5), 3'($urandom_range(0, 4)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
